// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem reads and queues returned words.
// Wrong-path responses after a Decode redirect are counted out and discarded.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00100000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_last_pc4;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_tag  [DEPTH];

  logic          w_redir;
  logic          w_issue;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [CW:0]   w_inflight;
  logic [31:0]   w_head_pc4;

  assign w_redir    = PCSrcD & ~StallF;
  assign w_inflight = {1'b0, r_out} + {1'b0, r_count};
  assign imem_req   = rst_n & ~w_redir & (w_inflight < LIM);
  assign imem_addr  = r_fetch_pc;
  assign w_issue    = imem_req & imem_gnt;

  assign w_valid    = (r_count != '0);
  assign w_drop     = imem_rvalid & (r_drop != '0);
  assign w_push     = imem_rvalid & ~w_drop & ~w_redir;
  assign w_pop      = w_valid & ~StallF & ~w_redir;

  assign w_head_pc4 = r_tag[r_rd_ptr] + 32'd4;
  assign ValidF     = w_valid;
  assign InstrF     = w_valid ? r_data[r_rd_ptr] : 32'd0;
  assign PCPlus4F   = w_valid ? w_head_pc4 : r_last_pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_last_pc4 <= RESET_PC;
      r_count    <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_valid)
        r_last_pc4 <= w_head_pc4;
      if (w_redir) begin
        // everything still in flight belongs to the wrong path
        r_fetch_pc <= PCBranchD;
        r_resp_pc  <= PCBranchD;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_out      <= r_out - CW'(imem_rvalid);
        r_drop     <= r_out - CW'(imem_rvalid);
      end else begin
        if (w_issue)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        r_out <= r_out + CW'(w_issue) - CW'(imem_rvalid);
        if (w_drop)
          r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + AW'(1);
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= imem_rdata;
      r_tag[r_wr_ptr]  <= r_resp_pc;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    w_push |-> (r_count != FULL));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model of
// programmable latency that returns the address as the data word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic        ValidF;

  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          cyc = 0;
  logic [31:0] exp_w;
  logic [63:0] pend [$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h00100000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallF      (StallF),
    .PCSrcD      (PCSrcD),
    .PCBranchD   (PCBranchD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PCPlus4F    (PCPlus4F),
    .ValidF      (ValidF)
  );

  // lat=N: data captured by the fetch unit N edges after the grant edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'd0;
    end else begin
      if (imem_req && imem_gnt)
        pend.push_back({32'(cyc + lat - 1), imem_addr});
      if (pend.size() > 0 && int'(pend[0][63:32]) <= cyc) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= pend[0][31:0];
        void'(pend.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'hDEADBEEF;
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic waitvalid(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ValidF && n < budget);
    chk(tag, 32'(ValidF), 32'd1);
  endtask

  task automatic drain(input string tag, input int n, input int budget);
    int got = 0;
    int c   = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      if (ValidF) begin
        chk(tag, InstrF, exp_w);
        chk({tag, "_pc4"}, PCPlus4F, exp_w + 32'd4);
        exp_w += 32'd4;
        got++;
      end
    end
    chk({tag, "_cnt"}, 32'(got), 32'(n));
  endtask

  task automatic quiesce(input string tag);
    imem_gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ValidF) begin
        chk(tag, InstrF, exp_w);
        exp_w += 32'd4;
      end
    end
    chk({tag, "_addr"}, imem_addr, exp_w);
  endtask

  initial begin
    rst_n     = 1'b0;
    StallF    = 1'b0;
    PCSrcD    = 1'b0;
    PCBranchD = 32'd0;
    imem_gnt  = 1'b0;
    lat       = 1;
    repeat (3) @(negedge clk);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ValidF),   32'd0);
    chk("rst_instr", InstrF,        32'd0);
    chk("rst_pc4",   PCPlus4F,      32'h00100000);

    rst_n = 1'b1;
    #1;
    chk("rel_req",  32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr,     32'h00100000);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_req",  32'(imem_req), 32'd1);
      chk("bp_addr", imem_addr,     32'h00100000);
    end

    imem_gnt = 1'b1;
    @(negedge clk);
    chk("fill_v0", 32'(ValidF), 32'd0);
    @(negedge clk);
    chk("fill_v1",    32'(ValidF), 32'd1);
    chk("fill_instr", InstrF,      32'h00100000);
    chk("fill_pc4",   PCPlus4F,    32'h00100004);
    exp_w = 32'h00100004;
    drain("stream", 3, 20);

    waitvalid("stall_wait", 10);
    chk("stall_head", InstrF, exp_w);
    StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_instr", InstrF,   exp_w);
      chk("stall_pc4",   PCPlus4F, exp_w + 32'd4);
    end
    chk("stall_req", 32'(imem_req), 32'd0);
    StallF = 1'b0;
    exp_w += 32'd4;
    drain("resume", 3, 20);
    quiesce("q1");

    lat      = 3;
    imem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    PCSrcD    = 1'b1;
    PCBranchD = 32'h00100040;
    #1;
    chk("redir_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    PCSrcD = 1'b0;
    chk("redir_addr", imem_addr,   32'h00100040);
    chk("redir_v",    32'(ValidF), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("redir_drop", 32'(ValidF), 32'd0);
    end
    waitvalid("redir_wait", 8);
    chk("redir_instr", InstrF,   32'h00100040);
    chk("redir_pc4",   PCPlus4F, 32'h00100044);
    exp_w = 32'h00100044;
    drain("redir", 2, 20);
    quiesce("q2");

    imem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    PCSrcD    = 1'b1;
    PCBranchD = 32'h00100080;
    #1;
    chk("rvr_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    PCSrcD = 1'b0;
    chk("rvr_v", 32'(ValidF), 32'd0);
    waitvalid("rvr_wait", 10);
    chk("rvr_instr", InstrF,   32'h00100080);
    chk("rvr_pc4",   PCPlus4F, 32'h00100084);

    StallF    = 1'b1;
    PCSrcD    = 1'b1;
    PCBranchD = 32'h00100200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("sm_instr", InstrF,      32'h00100080);
      chk("sm_valid", 32'(ValidF), 32'd1);
    end
    PCSrcD = 1'b0;
    StallF = 1'b0;
    exp_w  = 32'h00100084;
    drain("sm", 2, 20);

    StallF = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_pre",     InstrF,        exp_w - 32'd4);
    chk("ar_pre_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",   32'(imem_req), 32'd0);
    chk("ar_valid", 32'(ValidF),   32'd0);
    chk("ar_instr", InstrF,        32'd0);
    chk("ar_pc4",   PCPlus4F,      32'h00100000);
    @(negedge clk);
    rst_n    = 1'b1;
    lat      = 1;
    StallF   = 1'b0;
    imem_gnt = 1'b1;
    #1;
    chk("ar_req2",  32'(imem_req), 32'd1);
    chk("ar_addr",  imem_addr,     32'h00100000);
    exp_w = 32'h00100000;
    drain("restart", 3, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
